// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-rate enable, H/V counters and decoded sync/blanking.
// A frame in progress always finishes once started; it stops at the frame end unless en is re-raised.
module vga_timing_ctrl #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output logic       pixel_tick,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       busy
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       tick_q;
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       x_last;
    logic       y_last;
    logic       frame_end;

    // >= rather than == so an out-of-range count can never run past TOTAL-1
    assign x_last    = (x_q >= H_LAST);
    assign y_last    = (y_q >= V_LAST);
    assign frame_end = tick_q && x_last && y_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The frame-end wrap already yields tick=0 and (0,0), so leaving DRAIN needs no special case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (state_q == IDLE) begin
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            tick_q <= ~tick_q;
            if (tick_q) begin
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_last ? '0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        pixel_tick  = busy && tick_q;
        pixel_x     = x_q;
        pixel_y     = y_q;
        hsync_n     = !(busy && (x_q >= HS_START) && (x_q < HS_END));
        vsync_n     = !(busy && (y_q >= VS_START) && (y_q < VS_END));
        video_on    = busy && (x_q < H_VIS) && (y_q < V_VIS);
        frame_start = busy && tick_q && (x_q == '0) && (y_q == '0);
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a reduced 16x12 raster (hsync x=10..12, vsync y=8..9).
// Stimulus queues cycle-tagged expected outputs; the negedge monitor pops and compares them.
module tb_vga_timing_ctrl;

    localparam int unsigned HT = 16;
    localparam int unsigned VT = 12;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       pixel_tick;
    logic       hsync_n;
    logic       vsync_n;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
    logic       busy;

    vga_timing_ctrl #(
        .H_VISIBLE(8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_VISIBLE(6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .pixel_tick (pixel_tick),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_start(frame_start),
        .busy       (busy)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       busy;
        logic       tick;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fs;
    } exp_t;

    typedef struct {
        int unsigned cyc;
        string       name;
        exp_t        e;
    } item_t;

    item_t       sb[$];
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs k clocks after entering RUN, assuming uninterrupted counting.
    function automatic exp_t mk(input int unsigned k);
        exp_t        e;
        int unsigned p;
        int unsigned x;
        int unsigned y;
        p      = k / 2;
        x      = p % HT;
        y      = (p / HT) % VT;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.busy = 1'b1;
        e.tick = (k % 2) == 1;
        e.hs   = !(x >= 10 && x <= 12);
        e.vs   = !(y >= 8 && y <= 9);
        e.vo   = (x < 8) && (y < 6);
        e.fs   = e.tick && (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e      = '0;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        return e;
    endfunction

    task automatic push(input int unsigned c, input string nm, input exp_t e);
        item_t it;
        it.cyc  = c;
        it.name = nm;
        it.e    = e;
        sb.push_back(it);
    endtask

    task automatic push_run(input int unsigned k, input string nm);
        push(base + k, $sformatf("%s k=%0d", nm, k), mk(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) step();
    endtask

    always @(negedge clk) begin
        item_t it;
        exp_t  act;
        act = '{x: pixel_x, y: pixel_y, busy: busy, tick: pixel_tick,
                hs: hsync_n, vs: vsync_n, vo: video_on, fs: frame_start};
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            vectors++;
            if (it.cyc != cyc) begin
                miscompares++;
                $display("FAIL %s: not sampled at cycle %0d (now %0d)", it.name, it.cyc, cyc);
            end else if (act !== it.e) begin
                miscompares++;
                $display("FAIL %s: got x=%0d y=%0d busy=%b tick=%b hs_n=%b vs_n=%b vo=%b fs=%b, exp x=%0d y=%0d busy=%b tick=%b hs_n=%b vs_n=%b vo=%b fs=%b",
                         it.name, act.x, act.y, act.busy, act.tick, act.hs, act.vs, act.vo, act.fs,
                         it.e.x, it.e.y, it.e.busy, it.e.tick, it.e.hs, it.e.vs, it.e.vo, it.e.fs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d items pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        step();
        step();
        push(cyc, "reset en=0", idle_e());
        step();
        en = 1'b1;
        push(cyc, "reset en=1", idle_e());
        step();
        reset_n = 1'b1;

        // Phase A: free run from reset release, then drop en mid-frame and drain.
        step();
        base = cyc;
        push_run(0, "enter run");
        push_run(1, "first frame_start");
        push_run(2, "x advances");
        push_run(19, "before hsync");
        push_run(20, "hsync start t0");
        push_run(21, "hsync start t1");
        push_run(25, "hsync last");
        push_run(26, "after hsync");
        push_run(95, "line end (15,2)");
        push_run(96, "line wrap (0,3)");
        push_run(174, "last visible px");
        push_run(176, "h blank");
        push_run(192, "v blank");
        push_run(255, "before vsync");
        push_run(256, "vsync start");
        push_run(383, "frame last px");
        push_run(384, "frame wrap");
        push_run(385, "second frame_start");
        wait_until(base + 517);
        en = 1'b0;
        push_run(518, "drain at (3,4)");
        push_run(600, "draining");
        push_run(767, "drain last px");
        push(base + 768, "drain -> idle", idle_e());
        push(base + 800, "idle held", idle_e());
        wait_until(base + 800);

        // Phase B: en toggled inside DRAIN, including a re-raise on the final DRAIN edge.
        en = 1'b1;
        step();
        base = cyc;
        push_run(0, "restart run");
        push_run(30, "drain bounce a");
        push_run(60, "drain bounce b");
        wait_until(base + 9);
        en = 1'b0;
        wait_until(base + 49);
        en = 1'b1;
        wait_until(base + 299);
        en = 1'b0;
        push_run(383, "drain last px b");
        push_run(384, "rerun at frame end");
        push_run(385, "frame_start after rerun");
        push_run(400, "continued run");
        push_run(518, "pre-reset (3,4)");
        wait_until(base + 383);
        en = 1'b1;

        // Phase C: asynchronous reset mid-frame, then restart.
        wait_until(base + 519);
        push(cyc, "async reset", idle_e());
        #2;
        reset_n = 1'b0;
        step();
        push(cyc, "reset held", idle_e());
        step();
        reset_n = 1'b1;
        step();
        base = cyc;
        push_run(0, "post-reset run");
        push_run(1, "post-reset frame_start");
        push_run(2, "post-reset x=1");
        push_run(3, "post-reset tick");

        for (int unsigned i = 0; i < 50 && sb.size() != 0; i++) step();
        while (sb.size() != 0) begin
            item_t it;
            it = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never compared (expected at cycle %0d, now %0d)", it.name, it.cyc, cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
